// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi frame sequencer.
package viterbi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StData,
        StTail,
        StFlush,
        StDrain
    } state_e;

    localparam int unsigned TAIL_LEN_DEF = 2;
    localparam int unsigned SYM_W = 2;
    localparam logic [SYM_W-1:0] ZERO_SYM = 2'b00;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// Symbol, core and decoded-bit signals of the frame sequencer.
interface viterbi_frame_ctrl_if
    import viterbi_pkg::*;
#(
    parameter int unsigned LEN_W = 10
);
    logic             start_i;
    logic [LEN_W-1:0] cfg_len_i;
    logic [SYM_W-1:0] in_data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             core_clear_o;
    logic [SYM_W-1:0] core_data_o;
    logic             core_valid_o;
    logic             core_bit_i;
    logic             core_bit_valid_i;
    logic             out_data_o;
    logic             out_valid_o;
    logic             out_last_o;
    logic             busy_o;
    logic             done_o;
    logic             err_len_o;

    modport slave (
        input  start_i, cfg_len_i, in_data_i, in_valid_i, core_bit_i, core_bit_valid_i,
        output in_ready_o, core_clear_o, core_data_o, core_valid_o,
               out_data_o, out_valid_o, out_last_o, busy_o, done_o, err_len_o
    );

    modport master (
        output start_i, cfg_len_i, in_data_i, in_valid_i, core_bit_i, core_bit_valid_i,
        input  in_ready_o, core_clear_o, core_data_o, core_valid_o,
               out_data_o, out_valid_o, out_last_o, busy_o, done_o, err_len_o
    );

endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for viterbi_core: clears the core, forwards N symbols, appends
// zero tail and flush symbols, and trims the decoded stream to exactly N bits.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned LEN_W    = 10,
    parameter int unsigned TAIL_LEN = TAIL_LEN_DEF,
    parameter int unsigned TB_DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    viterbi_frame_ctrl_if.slave bus
);

    localparam int unsigned PH_MAX = (TB_DEPTH > TAIL_LEN) ? TB_DEPTH : TAIL_LEN;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [LEN_W:0]   out_cnt_q, out_cnt_d;
    logic [LEN_W:0]   out_end;
    logic [SYM_W-1:0] core_data_q, core_data_d;
    logic             core_valid_q, core_valid_d;
    logic             out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             hs;
    logic             bit_take;

    assign out_end  = {1'b0, len_q} + (LEN_W + 1)'(TAIL_LEN);
    assign hs       = (state_q == StData) && bus.in_valid_i;
    // Core bits seen in IDLE or CLEAR belong to an aborted or previous frame.
    assign bit_take = bus.core_bit_valid_i && (state_q inside {StData, StTail, StFlush, StDrain});

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sym_cnt_d    = sym_cnt_q;
        ph_cnt_d     = ph_cnt_q;
        out_cnt_d    = out_cnt_q;
        core_data_d  = ZERO_SYM;
        core_valid_d = 1'b0;
        out_data_d   = 1'b0;
        out_valid_d  = 1'b0;
        out_last_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        // Bits 0..N-1 are forwarded, tail bits only advance the saturating count.
        if (bit_take && (out_cnt_q < out_end)) begin
            out_cnt_d = out_cnt_q + (LEN_W + 1)'(1);
            if (out_cnt_q < {1'b0, len_q}) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.core_bit_i;
                out_last_d  = (out_cnt_q == ({1'b0, len_q} - (LEN_W + 1)'(1)));
            end
        end

        unique case (state_q)
            StIdle: begin
                sym_cnt_d = '0;
                ph_cnt_d  = '0;
                out_cnt_d = '0;
                if (bus.start_i) begin
                    if (bus.cfg_len_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = bus.cfg_len_i;
                        state_d = StClear;
                    end
                end
            end
            StClear: state_d = StData;
            StData: begin
                if (hs) begin
                    core_valid_d = 1'b1;
                    core_data_d  = bus.in_data_i;
                    if (sym_cnt_q == len_q - LEN_W'(1)) begin
                        state_d  = (TAIL_LEN == 0) ? StFlush : StTail;
                        ph_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + LEN_W'(1);
                    end
                end
            end
            StTail: begin
                core_valid_d = 1'b1;
                if (ph_cnt_q == PH_W'(TAIL_LEN - 1)) begin
                    state_d  = StFlush;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            StFlush: begin
                core_valid_d = 1'b1;
                if (ph_cnt_q == PH_W'(TB_DEPTH - 1)) begin
                    state_d  = StDrain;
                    ph_cnt_d = '0;
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            StDrain: begin
                // Leave on the same edge that registers the final bit so a start
                // presented alongside done is honoured.
                if (out_cnt_d == out_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= '0;
            sym_cnt_q    <= '0;
            ph_cnt_q     <= '0;
            out_cnt_q    <= '0;
            core_data_q  <= ZERO_SYM;
            core_valid_q <= 1'b0;
            out_data_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            sym_cnt_q    <= sym_cnt_d;
            ph_cnt_q     <= ph_cnt_d;
            out_cnt_q    <= out_cnt_d;
            core_data_q  <= core_data_d;
            core_valid_q <= core_valid_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready_o   = (state_q == StData);
    assign bus.core_clear_o = (state_q == StClear);
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.core_data_o  = core_data_q;
    assign bus.core_valid_o = core_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_last_o   = out_last_q;
    assign bus.done_o       = done_q;
    assign bus.err_len_o    = err_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench for viterbi_frame_ctrl with a behavioural stand-in for viterbi_core.
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int unsigned LEN_W    = 10;
    localparam int unsigned TAIL_LEN = 2;
    localparam int unsigned TB_DEPTH = 16;
    localparam int unsigned CORE_LAT = 3;

    typedef struct {
        bit data;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

    viterbi_frame_ctrl #(
        .LEN_W   (LEN_W),
        .TAIL_LEN(TAIL_LEN),
        .TB_DEPTH(TB_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   out_log[$];
    int   c_clear = 0, c_cvalid = 0, c_out = 0, c_last = 0, c_done = 0, c_err = 0;
    int   cur_run = 0, max_run = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Decoded bit of symbol k: even k -> MSB, odd k -> LSB; zero symbols decode to 0.
    function automatic bit decode(input int k, input logic [1:0] s);
        return (k % 2 == 0) ? s[1] : s[0];
    endfunction

    // Core stand-in: silent for the first TB_DEPTH symbols after clear, then one bit per symbol.
    initial begin : core_model
        bit pv[CORE_LAT];
        bit pd[CORE_LAT];
        bit sq[$];
        int scnt;
        scnt = 0;
        for (int i = 0; i < CORE_LAT; i++) begin pv[i] = 0; pd[i] = 0; end
        bus.core_bit_i       = 1'b0;
        bus.core_bit_valid_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < CORE_LAT; i++) begin pv[i] = 0; pd[i] = 0; end
                sq.delete();
                scnt = 0;
                bus.core_bit_valid_i = 1'b0;
                bus.core_bit_i       = 1'b0;
            end else begin
                bus.core_bit_valid_i = pv[0];
                bus.core_bit_i       = pd[0];
                for (int i = 0; i < CORE_LAT - 1; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
                pv[CORE_LAT-1] = 0;
                pd[CORE_LAT-1] = 0;
                if (bus.core_clear_o) begin sq.delete(); scnt = 0; end
                if (bus.core_valid_o) begin
                    sq.push_back(decode(scnt, bus.core_data_o));
                    scnt++;
                    if (scnt > TB_DEPTH) begin
                        pv[CORE_LAT-1] = 1;
                        pd[CORE_LAT-1] = sq.pop_front();
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.core_clear_o) c_clear++;
            if (bus.core_valid_o) begin
                c_cvalid++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (bus.done_o) c_done++;
            if (bus.err_len_o) c_err++;
            if (bus.out_valid_o) begin
                c_out++;
                out_log.push_back(bus.out_data_o);
                if (bus.out_last_o) c_last++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", int'(bus.out_valid_o), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'(bus.out_data_o), int'(e.data));
                    check("out_last", int'(bus.out_last_o), int'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input int n);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.cfg_len_i = LEN_W'(n);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic feed(input logic [1:0] s[$], input bit stall, input bit poke);
        int  i = 0;
        int  k = 0;
        bit  poked = 0;
        while (i < s.size() && k < 20000) begin
            bus.in_valid_i = stall ? (k % 3 == 0) : 1'b1;
            bus.in_data_i  = s[i];
            bus.start_i    = 1'b0;
            if (poke && !poked && i == 2) begin
                bus.start_i   = 1'b1;
                bus.cfg_len_i = '0;
                poked = 1;
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back('{data: decode(i, s[i]), last: (i == s.size() - 1)});
                i++;
            end
            k++;
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
        check("feed_complete", i, s.size());
        check("in_ready_fall", int'(bus.in_ready_o), 0);
    endtask

    task automatic wait_done(input bit poke, input int chain_n, output int outs_at_done,
                             output int cnt_at_done);
        int t = 0;
        bit seen = 0;
        bit poked = 0;
        outs_at_done = -1;
        cnt_at_done  = -1;
        while (!seen && t < 5000) begin
            @(negedge clk);
            t++;
            bus.start_i = 1'b0;
            if (bus.done_o) begin
                seen = 1;
                outs_at_done = c_out;
                cnt_at_done  = int'(dut.out_cnt_q);
            end else if (poke && !poked && bus.busy_o && !bus.in_ready_o && !bus.core_valid_o) begin
                bus.start_i   = 1'b1;
                bus.cfg_len_i = LEN_W'(3);
                poked = 1;
            end
        end
        check("done_seen", int'(seen), 1);
        if (poke) check("drain_poke_issued", int'(poked), 1);
        if (seen && chain_n > 0) begin
            bus.start_i   = 1'b1;
            bus.cfg_len_i = LEN_W'(chain_n);
            @(negedge clk);
            bus.start_i = 1'b0;
            check("b2b_clear_next_cycle", int'(bus.core_clear_o), 1);
        end
    endtask

    function automatic int out_bits_or();
        return int'({bus.in_ready_o, bus.core_clear_o, bus.core_data_o, bus.core_valid_o,
                     bus.out_data_o, bus.out_valid_o, bus.out_last_o, bus.busy_o, bus.done_o,
                     bus.err_len_o});
    endfunction

    initial begin : stim
        logic [1:0] syms[$];
        bit         bits_a[$];
        int         b_clear, b_cvalid, b_out, b_last, b_done, b_err, oad, ocnt;

        bus.start_i    = 1'b0;
        bus.cfg_len_i  = '0;
        bus.in_data_i  = '0;
        bus.in_valid_i = 1'b0;
        #3;
        check("reset_outputs", out_bits_or(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", out_bits_or(), 0);

        // Frame A: N=4, no stalls.
        syms = '{2'b11, 2'b10, 2'b01, 2'b11};
        @(posedge clk); #1;
        max_run = 0;
        b_clear = c_clear; b_cvalid = c_cvalid; b_out = c_out; b_last = c_last; b_done = c_done;
        b_err = c_err;
        out_log.delete();
        pulse_start(4);
        check("a_clear_after_start", int'(bus.core_clear_o), 1);
        feed(syms, 1'b0, 1'b0);
        wait_done(1'b0, 0, oad, ocnt);
        check("a_outs_at_done", oad - b_out, 4);
        check("a_out_cnt_sat", ocnt, 4 + TAIL_LEN);
        repeat (4) @(negedge clk);
        check("a_clear_pulses", c_clear - b_clear, 1);
        check("a_core_valid", c_cvalid - b_cvalid, 4 + TAIL_LEN + TB_DEPTH);
        check("a_core_valid_run", max_run, 4 + TAIL_LEN + TB_DEPTH);
        check("a_out_count", c_out - b_out, 4);
        check("a_last_count", c_last - b_last, 1);
        check("a_done_count", c_done - b_done, 1);
        check("a_busy_idle", int'(bus.busy_o), 0);
        check("a_scoreboard_empty", exp_q.size(), 0);
        bits_a = out_log;

        // Frame B: same symbols, input stalls.
        @(posedge clk); #1;
        max_run = 0;
        b_cvalid = c_cvalid; b_out = c_out; b_done = c_done;
        out_log.delete();
        pulse_start(4);
        feed(syms, 1'b1, 1'b0);
        wait_done(1'b0, 0, oad, ocnt);
        repeat (4) @(negedge clk);
        check("b_core_valid", c_cvalid - b_cvalid, 4 + TAIL_LEN + TB_DEPTH);
        check("b_core_valid_gaps", int'(max_run < 4 + TAIL_LEN + TB_DEPTH), 1);
        check("b_out_count", c_out - b_out, 4);
        check("b_done_count", c_done - b_done, 1);
        check("b_same_as_a", int'(out_log == bits_a), 1);

        // Zero-length start.
        b_clear = c_clear; b_cvalid = c_cvalid; b_err = c_err;
        pulse_start(0);
        check("err_pulse", int'(bus.err_len_o), 1);
        check("err_not_busy", int'(bus.busy_o), 0);
        @(negedge clk);
        check("err_one_cycle", int'(bus.err_len_o), 0);
        repeat (3) @(negedge clk);
        check("err_count", c_err - b_err, 1);
        check("err_no_clear", c_clear - b_clear, 0);
        check("err_no_core_valid", c_cvalid - b_cvalid, 0);

        // Starts during DATA and DRAIN are ignored.
        syms.delete();
        for (int i = 0; i < 6; i++) syms.push_back(2'($urandom_range(3)));
        b_clear = c_clear; b_out = c_out; b_done = c_done; b_err = c_err;
        pulse_start(6);
        feed(syms, 1'b0, 1'b1);
        wait_done(1'b1, 0, oad, ocnt);
        repeat (6) @(negedge clk);
        check("poke_out_count", c_out - b_out, 6);
        check("poke_done_count", c_done - b_done, 1);
        check("poke_no_err", c_err - b_err, 0);
        check("poke_one_clear", c_clear - b_clear, 1);
        check("poke_idle", int'(bus.busy_o), 0);

        // Reset during FLUSH, then an N=1 frame.
        syms.delete();
        for (int i = 0; i < 8; i++) syms.push_back(2'($urandom_range(3)));
        b_done = c_done;
        pulse_start(8);
        feed(syms, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("flush_core_valid", int'(bus.core_valid_o), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", out_bits_or(), 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_done", c_done - b_done, 0);
        syms = '{2'($urandom_range(3))};
        b_out = c_out; b_last = c_last; b_done = c_done;
        pulse_start(1);
        feed(syms, 1'b0, 1'b0);
        wait_done(1'b0, 0, oad, ocnt);
        repeat (4) @(negedge clk);
        check("n1_out_count", c_out - b_out, 1);
        check("n1_last_count", c_last - b_last, 1);
        check("n1_done_count", c_done - b_done, 1);

        // Two back-to-back N=1023 frames.
        syms.delete();
        for (int i = 0; i < 1023; i++) syms.push_back(2'($urandom_range(3)));
        b_out = c_out; b_last = c_last; b_done = c_done; b_clear = c_clear;
        pulse_start(1023);
        feed(syms, $urandom_range(1) == 1, 1'b0);
        wait_done(1'b0, 1023, oad, ocnt);
        check("big1_outs_at_done", oad - b_out, 1023);
        check("big1_out_cnt_sat", ocnt, 1023 + TAIL_LEN);
        syms.delete();
        for (int i = 0; i < 1023; i++) syms.push_back(2'($urandom_range(3)));
        feed(syms, 1'b0, 1'b0);
        wait_done(1'b0, 0, oad, ocnt);
        check("big2_out_cnt_sat", ocnt, 1023 + TAIL_LEN);
        repeat (4) @(negedge clk);
        check("big_out_count", c_out - b_out, 2046);
        check("big_last_count", c_last - b_last, 2);
        check("big_done_count", c_done - b_done, 2);
        check("big_clear_count", c_clear - b_clear, 2);
        check("big_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
